// File: rtl/apb_irq_ctrl.sv
// APB-programmed prioritised interrupt controller with request/ack/complete handshake.
// Define IRQ_CTRL_SYNC_EN to insert a 2-flop synchroniser on every irq_src bit.
module apb_irq_ctrl #(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = 4
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [4:0]         paddr,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  input  logic [NUM_SRC-1:0] irq_src,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     id_nxt, winner;
  logic [NUM_SRC-1:0]  pend, pend_nxt, enable, mode;
  logic [NUM_SRC-1:0]  s_src, prev_src, cand, id_sel, ack_clr, clr, edge_set;
  logic                id_cand, wr_en;
  logic                wr_enable, wr_mode, wr_clear, wr_complete;
  logic                unused_bits;

  assign pready      = 1'b1;
  assign wr_en       = psel & penable & pwrite;
  assign wr_enable   = wr_en && (paddr[4:2] == 3'd1);
  assign wr_mode     = wr_en && (paddr[4:2] == 3'd2);
  assign wr_clear    = wr_en && (paddr[4:2] == 3'd3);
  assign wr_complete = wr_en && (paddr[4:2] == 3'd5);
  assign unused_bits = ^{pwdata, paddr[1:0]};

`ifdef IRQ_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
    end
  end
  assign s_src = sync2;
`else
  assign s_src = irq_src;
`endif

  // Lowest index wins; id_sel is the one-hot of the latched irq_id.
  always_comb begin
    cand    = pend & enable;
    winner  = '0;
    id_sel  = '0;
    for (int unsigned i = NUM_SRC; i > 0; i--) begin
      if (cand[i-1]) winner = ID_W'(i - 1);
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      id_sel[i] = (irq_id == ID_W'(i));
    end
    id_cand = |(cand & id_sel);
  end

  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    ack_clr   = '0;
    case (state)
      IDLE: begin
        if (|cand) begin
          id_nxt    = winner;
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (!id_cand) begin
          state_nxt = IDLE;
        end else if (irq_ack) begin
          state_nxt = SERVICE;
          ack_clr   = id_sel;
        end
      end
      SERVICE: begin
        if (wr_complete && (pwdata[ID_W-1:0] == irq_id)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Edge bits: set beats clear. Level bits simply follow the synchronised input.
  always_comb begin
    edge_set = s_src & ~prev_src;
    clr      = ack_clr | (wr_clear ? pwdata[NUM_SRC-1:0] : '0);
    pend_nxt = (mode & (edge_set | (pend & ~clr))) | (~mode & s_src);
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      irq_id   <= '0;
      pend     <= '0;
      enable   <= '0;
      mode     <= '0;
      prev_src <= '0;
    end else begin
      state    <= state_nxt;
      irq_id   <= id_nxt;
      pend     <= pend_nxt;
      prev_src <= s_src;
      if (wr_enable) enable <= pwdata[NUM_SRC-1:0];
      if (wr_mode)   mode   <= pwdata[NUM_SRC-1:0];
    end
  end

  assign irq_out = (state == REQ);

  always_comb begin
    prdata = '0;
    case (paddr[4:2])
      3'd0: prdata[NUM_SRC-1:0] = pend;
      3'd1: prdata[NUM_SRC-1:0] = enable;
      3'd2: prdata[NUM_SRC-1:0] = mode;
      3'd4: begin
        prdata[1:0]      = state;
        prdata[8 +: ID_W] = irq_id;
      end
      default: prdata = '0;
    endcase
  end

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// Scoreboard bench for apb_irq_ctrl: expected values queued at stimulus time, popped at observation.
module tb_apb_irq_ctrl;

`ifdef IRQ_CTRL_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [4:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready;
  logic [7:0]  irq_src;
  logic        irq_out;
  logic [3:0]  irq_id;
  logic        irq_ack;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] expv, obs;
  int          n;

  apb_irq_ctrl #(.NUM_SRC(8), .ID_W(4)) dut (
    .pclk    (pclk),
    .rst_n   (rst_n),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .irq_src (irq_src),
    .irq_out (irq_out),
    .irq_id  (irq_id),
    .irq_ack (irq_ack)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic apb_write(input logic [4:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [4:0] addr, output logic [31:0] data);
    psel = 1'b1; pwrite = 1'b0; paddr = addr;
    #1;
    data = prdata;
    psel = 1'b0;
  endtask

  task automatic ack_pulse();
    irq_ack = 1'b1;
    step();
    irq_ack = 1'b0;
  endtask

  task automatic wait_irq(input logic level);
    n = 0;
    while (irq_out !== level && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    logic [4:0] addrs [4];
    addrs[0] = 5'h00; addrs[1] = 5'h04; addrs[2] = 5'h08; addrs[3] = 5'h10;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; irq_src = '0; irq_ack = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h1);
    step();
    for (int i = 0; i < 4; i++) begin
      apb_read(addrs[i], obs); expv = exp_q.pop_front(); tests++;
      if (obs !== expv) begin fails++; $display("FAIL reset_reg_%0h: got %h expected %h", addrs[i], obs, expv); end
    end
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL reset_irq: got %h expected %h", obs, expv); end
    obs = 32'(pready); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL reset_pready: got %h expected %h", obs, expv); end
  endtask

  task automatic test_regs();
    apb_write(5'h04, 32'hFFFF_FFFF);
    exp_q.push_back(32'h0000_00FF);
    apb_read(5'h04, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL enable_width: got %h expected %h", obs, expv); end
    apb_write(5'h04, 32'h0);
    exp_q.push_back(32'h0);
    apb_read(5'h1C, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL unmapped_read: got %h expected %h", obs, expv); end
    exp_q.push_back(32'h0);
    apb_read(5'h0C, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL clear_reads_zero: got %h expected %h", obs, expv); end
  endtask

  task automatic test_edge();
    apb_write(5'h04, 32'h01);
    apb_write(5'h08, 32'h01);
    irq_src[0] = 1'b1;
    if (SYNC_LAT > 0) exp_q.push_back(32'h0);
    exp_q.push_back(32'h01);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h10);
    for (int k = 1; k <= SYNC_LAT + 2; k++) begin
      step();
      if (k == 1) irq_src[0] = 1'b0;
      if (k == SYNC_LAT) begin
        apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
        if (obs !== expv) begin fails++; $display("FAIL edge_pend_early: got %h expected %h", obs, expv); end
      end
      if (k == SYNC_LAT + 1) begin
        apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
        if (obs !== expv) begin fails++; $display("FAIL edge_pend_set: got %h expected %h", obs, expv); end
        obs = 32'(irq_out); expv = exp_q.pop_front(); tests++;
        if (obs !== expv) begin fails++; $display("FAIL edge_irq_not_yet: got %h expected %h", obs, expv); end
      end
      if (k == SYNC_LAT + 2) begin
        obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
        if (obs !== expv) begin fails++; $display("FAIL edge_irq_req: got %h expected %h", obs, expv); end
      end
    end
    ack_pulse();
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h002);
    exp_q.push_back(32'h0);
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL ack_pend_clr: got %h expected %h", obs, expv); end
    apb_read(5'h10, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL ack_state: got %h expected %h", obs, expv); end
    obs = 32'(irq_out); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL ack_irq_low: got %h expected %h", obs, expv); end
    apb_write(5'h14, 32'h0);
    exp_q.push_back(32'h0);
    apb_read(5'h10, obs); obs = obs & 32'h3; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL complete_idle: got %h expected %h", obs, expv); end
  endtask

  task automatic test_priority();
    apb_write(5'h04, 32'hFF);
    apb_write(5'h08, 32'hFF);
    irq_src[5] = 1'b1;
    exp_q.push_back(32'h15);
    wait_irq(1'b1);
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL prio_first: got %h expected %h", obs, expv); end
    irq_src[2] = 1'b1;
    exp_q.push_back(32'h15);
    exp_q.push_back(32'h24);
    repeat (6) step();
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL prio_no_preempt: got %h expected %h", obs, expv); end
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL prio_pend: got %h expected %h", obs, expv); end
    ack_pulse();
    apb_write(5'h14, 32'h5);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h12);
    obs = 32'(irq_out); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL prio_idle_gap: got %h expected %h", obs, expv); end
    step();
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL prio_next: got %h expected %h", obs, expv); end
    ack_pulse();
    apb_write(5'h14, 32'h2);
    irq_src = '0;
    repeat (4) step();
  endtask

  task automatic test_level();
    apb_write(5'h08, 32'h00);
    apb_write(5'h04, 32'h08);
    irq_src[3] = 1'b1;
    exp_q.push_back(32'h13);
    wait_irq(1'b1);
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_req: got %h expected %h", obs, expv); end
    ack_pulse();
    exp_q.push_back(32'h302);
    exp_q.push_back(32'h08);
    apb_read(5'h10, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_service: got %h expected %h", obs, expv); end
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_ack_keeps_pend: got %h expected %h", obs, expv); end
    apb_write(5'h14, 32'h3);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h13);
    obs = 32'(irq_out); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_idle_gap: got %h expected %h", obs, expv); end
    step();
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_rereq: got %h expected %h", obs, expv); end
    irq_src[3] = 1'b0;
    exp_q.push_back(32'h0);
    wait_irq(1'b0);
    apb_read(5'h10, obs); obs = obs & 32'h3; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL level_drop_idle: got %h expected %h", obs, expv); end
  endtask

  task automatic test_mask_clear();
    apb_write(5'h08, 32'hFF);
    apb_write(5'h04, 32'h00);
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    exp_q.push_back(32'h02);
    exp_q.push_back(32'h0);
    repeat (6) step();
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mask_pend: got %h expected %h", obs, expv); end
    obs = 32'(irq_out); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mask_no_irq: got %h expected %h", obs, expv); end
    // CLEAR write lands on the same edge that detects a fresh rising edge
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 5'h0C; pwdata = 32'h02;
    step();
    irq_src[1] = 1'b1;
    repeat (SYNC_LAT) step();
    penable = 1'b1;
    step();
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    exp_q.push_back(32'h02);
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL clear_set_wins: got %h expected %h", obs, expv); end
    irq_src[1] = 1'b0;
    repeat (4) step();
    apb_write(5'h0C, 32'h02);
    exp_q.push_back(32'h0);
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL clear_edge: got %h expected %h", obs, expv); end
    apb_write(5'h04, 32'h02);
    irq_src[1] = 1'b1;
    step();
    irq_src[1] = 1'b0;
    exp_q.push_back(32'h11);
    wait_irq(1'b1);
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mask_enabled_req: got %h expected %h", obs, expv); end
    ack_pulse();
    apb_write(5'h14, 32'h4);
    exp_q.push_back(32'h102);
    apb_read(5'h10, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL complete_wrong_id: got %h expected %h", obs, expv); end
  endtask

  task automatic test_reset_mid();
    irq_src[4] = 1'b1;
    step();
    irq_src[4] = 1'b0;
    exp_q.push_back(32'h10);
    repeat (6) step();
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mid_pend_pre: got %h expected %h", obs, expv); end
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'h0);
    #1;
    obs = {27'b0, irq_out, irq_id}; expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mid_rst_irq: got %h expected %h", obs, expv); end
    apb_read(5'h10, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mid_rst_state: got %h expected %h", obs, expv); end
    apb_read(5'h00, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mid_rst_pend: got %h expected %h", obs, expv); end
    apb_read(5'h04, obs); expv = exp_q.pop_front(); tests++;
    if (obs !== expv) begin fails++; $display("FAIL mid_rst_enable: got %h expected %h", obs, expv); end
    step();
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_regs();
    test_edge();
    test_priority();
    test_level();
    test_mask_clear();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_irq_ctrl.md
Name: apb_irq_ctrl

Overview:
- Interrupt controller that collects the irq outputs of the timer/counter instances and other peripherals and presents one prioritised request, with a source ID, to a core.
- Programmed over APB on pclk.
- Each source has a mask bit, an edge/level mode bit and a pending bit.
- A three-state handshake with the core (request, acknowledge, complete) makes sure the same source is never re-delivered while it is in service.

Parameters:
- NUM_SRC, 8: number of interrupt sources, legal range 1..16.
- ID_W, 4: width of the source ID; must satisfy 2^ID_W >= NUM_SRC.

Ports:
- pclk  input  1  APB and controller clock
- rst_n  input  1  asynchronous, active-low reset
- psel  input  1  APB select
- penable  input  1  APB enable (access phase)
- pwrite  input  1  APB write
- paddr  input  5  byte address; bits [1:0] are ignored
- pwdata  input  32  APB write data
- prdata  output  32  APB read data, combinational from paddr
- pready  output  1  tied to 1 (no wait states)
- irq_src  input  NUM_SRC  raw interrupt inputs; may be asynchronous to pclk
- irq_out  output  1  interrupt request to the core
- irq_id  output  ID_W  ID of the source being requested or serviced
- irq_ack  input  1  one-cycle pulse from the core accepting the request

Behaviour:
- Reset:
  - Reset is asynchronous on rst_n low, and clears everything at any point, including mid-service: all registers and synchronisers go to 0, the state goes to IDLE, irq_out=0 and irq_id=0.
  - prdata follows paddr and returns 0 for addresses that are not mapped.
- APB access:
  - A write takes effect on the pclk edge where psel & penable & pwrite are all high.
  - Reads have no side effects.
- Register map:
  - 0x00 PEND (RO): pending bits [NUM_SRC-1:0].
  - 0x04 ENABLE (RW): mask; a 1 allows the source to request.
  - 0x08 MODE (RW): 1 = rising-edge, 0 = level.
  - 0x0C CLEAR (WO, reads 0): writing 1 clears pending for edge-mode sources; has no effect on level-mode bits.
  - 0x10 STATE (RO): [1:0] = state, [11:8] = irq_id.
  - 0x14 COMPLETE (WO): pwdata[ID_W-1:0] = ID being completed.
  - Bits above NUM_SRC read 0 and are not writable.
- Input path:
  - Each irq_src bit passes through the synchroniser (see the optional feature) to give s_src.
  - The previous value is kept for edge detection.
- Pending rules:
  - Edge mode: a pending bit is set when s_src goes 0 to 1. It is cleared by CLEAR, or by irq_ack when that source is the one being requested.
  - If set and clear happen in the same cycle, set wins.
  - Level mode: pending = s_src each cycle, and ack does not clear it.
  - A masked source still latches pending; it simply does not request.
  - Changing MODE from edge to level makes the bit track the level on the next cycle.
- Priority: candidates = PEND & ENABLE; the lowest index wins.
- State machine:
  - IDLE (0): irq_out=0. When candidates != 0, latch the winner into irq_id and go to REQ.
  - REQ (1): irq_out=1.
    - On irq_ack, go to SERVICE and clear the winner's pending bit if it is edge-mode.
    - If the winner's candidate bit drops before ack (masked, cleared, or level gone), go back to IDLE with irq_out=0.
    - A higher-priority arrival while in REQ does not change irq_id.
  - SERVICE (2): irq_out=0 and irq_id is held.
    - A COMPLETE write whose ID equals irq_id returns to IDLE.
    - A COMPLETE write with any other ID is ignored.
    - irq_ack in IDLE or SERVICE is ignored.
- Latency, with the synchroniser present:
  - Source rising at pclk edge 0 → PEND bit set at edge 3 → irq_out high at edge 4.
  - COMPLETE write edge → back in IDLE; the next request can raise irq_out one cycle later.
  - A level source that is still high after COMPLETE re-requests.

Optional Feature:
- Macro: IRQ_CTRL_SYNC_EN.
- Defined: each irq_src bit goes through a 2-flop synchroniser and s_src lags irq_src by 2 cycles. Use this when sources are on the timer clk domain.
- Undefined: s_src = irq_src directly, so every latency above is 2 cycles shorter. Use this only when all sources are already synchronous to pclk.

Test Plan:
- Reset values: reset, then read 0x00/0x04/0x08/0x10 → all 0; irq_out=0, pready=1.
- Edge request and handshake:
  - ENABLE=0x01, MODE=0x01; pulse irq_src[0] for 1 cycle → PEND=0x01 at edge 3, irq_out=1 with irq_id=0 at edge 4.
  - Pulse irq_ack → PEND=0x00, STATE=2, irq_out=0.
  - Write COMPLETE=0 → STATE=0.
- Priority and no preemption:
  - ENABLE=0xFF, MODE=0xFF; raise irq_src[5] → irq_id=5 in REQ.
  - Then raise irq_src[2] → irq_id stays 5.
  - Ack, then COMPLETE=5 → the next request has irq_id=2.
- Level mode:
  - MODE=0x00, ENABLE=0x08; hold irq_src[3] high → request ID 3.
  - Ack, then COMPLETE=3 while the source is still high → irq_out reasserts with ID 3.
  - Drop the source while in REQ → return to IDLE, irq_out=0.
- Masking and CLEAR:
  - ENABLE=0, edge on source 1 → PEND=0x02, irq_out stays 0.
  - Write CLEAR=0x02 in the same cycle as a new edge → PEND stays 0x02 (set wins).
  - COMPLETE with the wrong ID while in SERVICE → STATE stays 2.
- Reset mid-service: assert rst_n low while in SERVICE with PEND=0x10 → immediately STATE=0, PEND=0, irq_out=0, irq_id=0.
